// File: rtl/spi_loader.sv
// ---------------------------------------------------------------------------
// spi_loader
//
// Copies an image from a W25Q-class SPI NOR flash into a bit-addressed buffer.
// Entering ACCTYPE code 110 loads a 1024-byte bootloader from the start of
// the selected image slot. Entering code 111 loads one 64-byte page from the
// page region of that slot. The flash is read with a Standard Read (0x03)
// in SPI mode 0. Each SPI bit takes two MCLK cycles, so CLK = MCLK/2.
//
// Ports
//   MCLK      in   1   master clock, all logic on the rising edge
//   nRESET    in   1   asynchronous active-low reset
//   IMGNUM    in   3   image slot select (0-7)
//   ACCTYPE   in   3   access request code (110 boot, 111 page)
//   ABSPOS    in  12   absolute page position (0-4095)
//   BUFWADDR  out 15   buffer write bit address
//   BUFWDATA  out  1   buffer write data bit
//   BUFWCLK   out  1   buffer write strobe, one MCLK per bit
//   nCS       out  1   flash chip select, active low
//   MOSI      out  1   flash serial data in
//   MISO      in   1   flash serial data out
//   CLK       out  1   flash serial clock, idles low
//   nWP       out  1   flash write protect, held high
//   nHOLD     out  1   flash hold / reset, held high
// ---------------------------------------------------------------------------
module spi_loader (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic [2:0]  IMGNUM,
    input  logic [2:0]  ACCTYPE,
    input  logic [11:0] ABSPOS,
    output logic [14:0] BUFWADDR,
    output logic        BUFWDATA,
    output logic        BUFWCLK,
    output logic        nCS,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CLK,
    output logic        nWP,
    output logic        nHOLD
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [2:0]  ACC_BOOT      = 3'b110;
    localparam logic [2:0]  ACC_PAGE      = 3'b111;
    localparam logic [7:0]  CMD_READ      = 8'h03;
    localparam logic [21:0] PAGE_REGION   = 22'h040000;
    localparam logic [12:0] LAST_BOOT_BIT = 13'd8191;
    localparam logic [12:0] LAST_PAGE_BIT = 13'd511;
    localparam logic [4:0]  LAST_CMD_BIT  = 5'd7;
    localparam logic [4:0]  LAST_HDR_BIT  = 5'd31;

    state_t      state;
    logic [2:0]  prev_acctype;
    logic        code_entry;
    logic        phase;
    logic [4:0]  hdr_cnt;
    logic [30:0] hdr_sr;
    logic [12:0] data_cnt;
    logic [12:0] last_bit;
    logic        cs_guard;
    logic [21:0] boot_addr;
    logic [21:0] page_addr;
    logic [21:0] start_addr;
    logic [12:0] start_last;

    // A load request is a transition into code 110/111. Holding the code
    // does not count. A transition that arrives while busy is also ignored,
    // because the IDLE branch below is the only place that acts on it.
    always_comb begin
        code_entry = ((ACCTYPE == ACC_BOOT) || (ACCTYPE == ACC_PAGE)) &&
                     (ACCTYPE != prev_acctype);
    end

    // Flash byte address and last bit index for the request that is
    // currently on the inputs. These are used only on the start edge.
    always_comb begin
        boot_addr  = {IMGNUM, 19'h00000};
        page_addr  = boot_addr + PAGE_REGION + {4'b0000, ABSPOS, 6'b000000};
        start_addr = (ACCTYPE == ACC_BOOT) ? boot_addr : page_addr;
        start_last = (ACCTYPE == ACC_BOOT) ? LAST_BOOT_BIT : LAST_PAGE_BIT;
    end

    // Previous-code register. It is updated every cycle, including during a
    // load, so that a code held through a load cannot retrigger afterwards.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            prev_acctype <= 3'b000;
        end else begin
            prev_acctype <= ACCTYPE;
        end
    end

    // Main sequencer. phase 0 is the first MCLK of an SPI bit: CLK is low
    // and MOSI holds the bit. phase 1 is the second MCLK: CLK is high.
    //
    // The edge that leaves phase 0 raises CLK and samples MISO. In DATA,
    // that same edge raises BUFWCLK for one cycle with the sampled bit.
    //
    // hdr_sr holds the header bits that come after the one now on MOSI.
    // The first bit goes straight to MOSI on the start edge.
    //
    // cs_guard keeps IDLE from starting on its first cycle, so nCS stays
    // high for at least two MCLK between loads.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            nCS      <= 1'b1;
            CLK      <= 1'b0;
            MOSI     <= 1'b0;
            BUFWCLK  <= 1'b0;
            BUFWDATA <= 1'b0;
            BUFWADDR <= 15'd0;
            phase    <= 1'b0;
            hdr_cnt  <= 5'd0;
            hdr_sr   <= 31'd0;
            data_cnt <= 13'd0;
            last_bit <= 13'd0;
            cs_guard <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nCS     <= 1'b1;
                    CLK     <= 1'b0;
                    MOSI    <= 1'b0;
                    BUFWCLK <= 1'b0;
                    if (cs_guard) begin
                        cs_guard <= 1'b0;
                    end else if (code_entry) begin
                        nCS      <= 1'b0;
                        MOSI     <= CMD_READ[7];
                        hdr_sr   <= {CMD_READ[6:0], 2'b00, start_addr};
                        hdr_cnt  <= 5'd0;
                        phase    <= 1'b0;
                        data_cnt <= 13'd0;
                        last_bit <= start_last;
                        state    <= CMD;
                    end
                end

                CMD, ADDR: begin
                    if (!phase) begin
                        CLK   <= 1'b1;
                        phase <= 1'b1;
                    end else begin
                        CLK     <= 1'b0;
                        phase   <= 1'b0;
                        hdr_cnt <= hdr_cnt + 5'd1;
                        hdr_sr  <= {hdr_sr[29:0], 1'b0};
                        if (hdr_cnt == LAST_HDR_BIT) begin
                            MOSI  <= 1'b0;
                            state <= DATA;
                        end else begin
                            MOSI <= hdr_sr[30];
                            if (hdr_cnt == LAST_CMD_BIT) begin
                                state <= ADDR;
                            end
                        end
                    end
                end

                DATA: begin
                    if (!phase) begin
                        CLK      <= 1'b1;
                        phase    <= 1'b1;
                        BUFWCLK  <= 1'b1;
                        BUFWDATA <= MISO;
                        BUFWADDR <= {2'b00, data_cnt};
                    end else begin
                        CLK      <= 1'b0;
                        phase    <= 1'b0;
                        BUFWCLK  <= 1'b0;
                        data_cnt <= data_cnt + 13'd1;
                        if (data_cnt == last_bit) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    nCS      <= 1'b1;
                    cs_guard <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The flash is never written, and its hold/reset pin is never used.
    always_comb begin
        nWP   = 1'b1;
        nHOLD = 1'b1;
    end

endmodule

// File: tb/tb_spi_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_loader
//
// Testbench for spi_loader. It connects the DUT to a behavioural W25Q32JV
// that supports Standard Read (0x03). Flash contents come from a seeded hash
// of the byte address.
//
// Each load request pushes the bits the buffer should receive into a
// scoreboard queue. A separate monitor pops one entry per BUFWCLK strobe and
// compares it.
// ---------------------------------------------------------------------------
module tb_spi_loader;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [2:0]  IMGNUM = 3'd0;
    logic [2:0]  ACCTYPE = 3'd0;
    logic [11:0] ABSPOS = 12'd0;
    logic [14:0] BUFWADDR;
    logic        BUFWDATA;
    logic        BUFWCLK;
    logic        nCS;
    logic        MOSI;
    logic        MISO = 1'b0;
    logic        CLK;
    logic        nWP;
    logic        nHOLD;

    int          checks = 0;
    int          failures = 0;
    int          strobe_cnt = 0;
    int          exp_base = 0;
    int          exp_bits = 0;
    int unsigned flash_seed = 0;
    logic [15:0] exp_q[$];

    int          fl_cnt = 0;
    logic [7:0]  fl_cmd = 8'h00;
    logic [23:0] fl_addr = 24'h000000;

    spi_loader dut (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .IMGNUM   (IMGNUM),
        .ACCTYPE  (ACCTYPE),
        .ABSPOS   (ABSPOS),
        .BUFWADDR (BUFWADDR),
        .BUFWDATA (BUFWDATA),
        .BUFWCLK  (BUFWCLK),
        .nCS      (nCS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .CLK      (CLK),
        .nWP      (nWP),
        .nHOLD    (nHOLD)
    );

    // 50 MHz master clock.
    always #10 MCLK = ~MCLK;

    // Flash contents: a seeded hash of the byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [31:0] x;
        x = ({8'h00, a} * 32'h9E3779B1) ^ flash_seed;
        x = x ^ (x >> 15);
        return x[7:0] ^ x[23:16];
    endfunction

    // Start address of a load, computed directly from the addressing rules.
    function automatic int loadBase(input int img, input int pos, input bit boot);
        if (boot) return img * 524288;
        return img * 524288 + 262144 + pos * 64;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Queue every buffer bit a load should produce, in write order.
    task automatic pushExpected(input int base, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            logic [7:0] b;
            b = flash_byte(24'(base + k / 8));
            exp_q.push_back({15'(k), b[7 - (k % 8)]});
        end
    endtask

    // Drive the request inputs. When expect_load is set, also record the
    // load this request should start.
    task automatic applyStimulus(input int img, input int pos,
                                 input logic [2:0] code, input bit expect_load);
        IMGNUM  = 3'(img);
        ABSPOS  = 12'(pos);
        ACCTYPE = code;
        if (expect_load) begin
            exp_base   = loadBase(img, pos, code == 3'b110);
            exp_bits   = (code == 3'b110) ? 8192 : 512;
            strobe_cnt = 0;
            pushExpected(exp_base, exp_bits);
        end
    endtask

    // Wait for a started load to finish, then check it.
    // With disturb set, the request inputs are changed mid-load; the load
    // must ignore them, including a new code entry.
    task automatic finishLoad(input bit disturb);
        bit got_low;
        int n;
        got_low = 0;
        for (int c = 0; c < 2 && !got_low; c++) begin
            @(negedge MCLK);
            if (!nCS) got_low = 1;
        end
        checkOutput("cs_assert_within_2", 32'(got_low), 32'd1);
        if (disturb) begin
            repeat (50) @(negedge MCLK);
            IMGNUM  = 3'($urandom_range(7, 0));
            ABSPOS  = 12'($urandom_range(4095, 0));
            ACCTYPE = 3'b000;
            @(negedge MCLK);
            ACCTYPE = ($urandom_range(1, 0) == 1) ? 3'b110 : 3'b111;
        end
        n = 0;
        while (!nCS && n < 17000) begin
            @(negedge MCLK);
            n++;
        end
        checkOutput("load_done_in_time", 32'(n < 17000), 32'd1);
        repeat (4) @(negedge MCLK);
        checkOutput("strobe_count", 32'(strobe_cnt), 32'(exp_bits));
        checkOutput("flash_cmd", {24'd0, fl_cmd}, 32'h03);
        checkOutput("flash_addr", {8'd0, fl_addr}, 32'(exp_base));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic runLoad(input int img, input int pos, input bit boot,
                           input bit disturb);
        @(negedge MCLK);
        ACCTYPE = 3'b000;
        @(negedge MCLK);
        applyStimulus(img, pos, boot ? 3'b110 : 3'b111, 1'b1);
        finishLoad(disturb);
    endtask

    // Flash model: shift in the command and 24-bit address on rising CLK.
    // After the header, MOSI must stay 0.
    always @(negedge nCS) begin
        fl_cnt  = 0;
        fl_cmd  = 8'h00;
        fl_addr = 24'h000000;
    end

    always @(posedge CLK) begin
        if (!nCS) begin
            if (fl_cnt < 8) fl_cmd = {fl_cmd[6:0], MOSI};
            else if (fl_cnt < 32) fl_addr = {fl_addr[22:0], MOSI};
            else checkOutput("mosi_zero_in_data", {31'd0, MOSI}, 32'd0);
            fl_cnt++;
        end
    end

    // Flash model: shift out data MSB first on falling CLK once the address
    // is complete.
    always @(negedge CLK or posedge nCS) begin : miso_drv
        int         j;
        logic [7:0] b;
        if (nCS) begin
            MISO <= 1'b0;
        end else if (fl_cnt >= 32) begin
            j = fl_cnt - 32;
            b = flash_byte(fl_addr + 24'(j / 8));
            MISO <= b[7 - (j % 8)];
        end
    end

    // Monitor: one scoreboard entry per strobe. It also checks the pins that
    // must be quiet whenever the flash is deselected.
    always @(negedge MCLK) begin
        if (nRESET) begin
            checkOutput("wp_hold_high", {30'd0, nWP, nHOLD}, 32'd3);
            if (nCS) checkOutput("idle_pins", {29'd0, CLK, MOSI, BUFWCLK}, 32'd0);
            if (BUFWCLK) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_strobe: got addr %0d, expected no write at %0t",
                             BUFWADDR, $time);
                end else begin
                    checkOutput("buffer_write", {16'd0, BUFWADDR, BUFWDATA},
                                {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #4ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit low_seen;
        int saved;
        int n;
        flash_seed = $urandom;
        repeat (3) @(negedge MCLK);

        // Reset state.
        checkOutput("rst_ncs", {31'd0, nCS}, 32'd1);
        checkOutput("rst_clk", {31'd0, CLK}, 32'd0);
        checkOutput("rst_mosi", {31'd0, MOSI}, 32'd0);
        checkOutput("rst_bufwclk", {31'd0, BUFWCLK}, 32'd0);
        checkOutput("rst_bufwdata", {31'd0, BUFWDATA}, 32'd0);
        checkOutput("rst_bufwaddr", {17'd0, BUFWADDR}, 32'd0);
        checkOutput("rst_nwp", {31'd0, nWP}, 32'd1);
        checkOutput("rst_nhold", {31'd0, nHOLD}, 32'd1);
        nRESET = 1'b1;
        repeat (3) @(negedge MCLK);

        // Bootloader load from slot 0.
        $display("[TB] bootloader load, slot 0");
        runLoad(0, 0, 1'b1, 1'b0);
        checkOutput("boot0_addr", {8'd0, fl_addr}, 32'h000000);

        // 000 -> 001 -> 111: code 001 must not start a load.
        $display("[TB] page load, slot 0, position 1018");
        @(negedge MCLK);
        applyStimulus(0, 1018, 3'b000, 1'b0);
        @(negedge MCLK);
        ACCTYPE  = 3'b001;
        low_seen = 0;
        repeat (10) begin
            @(negedge MCLK);
            if (!nCS) low_seen = 1;
        end
        checkOutput("code001_no_start", 32'(low_seen), 32'd0);
        applyStimulus(0, 1018, 3'b111, 1'b1);
        finishLoad(1'b0);
        checkOutput("page1018_addr", {8'd0, fl_addr}, 32'h04FE80);

        // Slot 5 bootloader, then hold code 110: no retrigger.
        $display("[TB] bootloader load, slot 5, code held");
        runLoad(5, 0, 1'b1, 1'b0);
        checkOutput("boot5_addr", {8'd0, fl_addr}, 32'h280000);
        saved    = strobe_cnt;
        low_seen = 0;
        repeat (3000) begin
            @(negedge MCLK);
            if (!nCS) low_seen = 1;
        end
        checkOutput("held_no_retrigger", 32'(low_seen), 32'd0);
        checkOutput("held_no_strobes", 32'(strobe_cnt), 32'(saved));

        // Highest page address: slot 7, position 4095.
        runLoad(7, 4095, 1'b0, 1'b0);
        checkOutput("page_top_addr", {8'd0, fl_addr}, 32'h3FFFC0);

        // Random page loads, half with the inputs disturbed mid-load.
        $display("[TB] randomized page loads");
        for (int i = 0; i < 6; i++) begin
            runLoad(int'($urandom_range(7, 0)), int'($urandom_range(4095, 0)),
                    1'b0, (i % 2) == 1);
        end

        // Reset in the middle of DATA.
        $display("[TB] reset during data phase");
        @(negedge MCLK);
        ACCTYPE = 3'b000;
        @(negedge MCLK);
        applyStimulus(3, 77, 3'b111, 1'b1);
        n = 0;
        while (strobe_cnt < 100 && n < 2000) begin
            @(negedge MCLK);
            n++;
        end
        checkOutput("reached_data", 32'(strobe_cnt >= 100), 32'd1);
        @(posedge MCLK);
        #3;
        nRESET = 1'b0;
        #1;
        checkOutput("abort_ncs", {31'd0, nCS}, 32'd1);
        checkOutput("abort_clk", {31'd0, CLK}, 32'd0);
        checkOutput("abort_bufwclk", {31'd0, BUFWCLK}, 32'd0);
        exp_q.delete();
        ACCTYPE = 3'b000;
        repeat (3) @(negedge MCLK);
        nRESET   = 1'b1;
        saved    = strobe_cnt;
        low_seen = 0;
        repeat (300) begin
            @(negedge MCLK);
            if (!nCS) low_seen = 1;
        end
        checkOutput("post_abort_idle", 32'(low_seen), 32'd0);
        checkOutput("post_abort_no_strobes", 32'(strobe_cnt), 32'(saved));

        // Code 111 already present at reset release counts as a code entry.
        $display("[TB] code present at reset release");
        @(negedge MCLK);
        nRESET = 1'b0;
        @(negedge MCLK);
        applyStimulus(2, int'($urandom_range(4095, 0)), 3'b111, 1'b1);
        nRESET = 1'b1;
        finishLoad(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
